// File: rtl/mux4_scan_ctrl.sv
// Scan controller for a downstream 4:1 mux: steps enabled channels,
// waits dwell cycles per channel, samples mux_o and publishes a frame.
module mux4_scan_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic [3:0] mask,
  input  logic [3:0] dwell,
  input  logic       mux_o,
  output logic       s1,
  output logic       s2,
  output logic [3:0] frame,
  output logic       frame_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ch_q, ch_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] mask_l_q, mask_l_d;
  logic [3:0] dwell_l_q, dwell_l_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] frame_q, frame_d;
  logic [2:0] pick_first, pick_next;

  // Lowest enabled channel >= lo; bit 2 set means none left.
  function automatic logic [2:0] pick(
    input logic [3:0] m,
    input logic [2:0] lo
  );
    logic [2:0] r;
    r = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (3'(i) >= lo)) r = 3'(i);
    end
    return r;
  endfunction

  assign pick_first = pick(mask, 3'd0);
  assign pick_next  = pick(mask_l_q, {1'b0, ch_q} + 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= 2'd0;
      cnt_q     <= 4'd0;
      mask_l_q  <= 4'd0;
      dwell_l_q <= 4'd0;
      shadow_q  <= 4'd0;
      frame_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      mask_l_q  <= mask_l_d;
      dwell_l_q <= dwell_l_d;
      shadow_q  <= shadow_d;
      frame_q   <= frame_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    mask_l_d  = mask_l_q;
    dwell_l_d = dwell_l_q;
    shadow_d  = shadow_q;
    unique case (state_q)
      IDLE, DONE: begin
        if ((state_q == IDLE && start) ||
            (state_q == DONE && cont)) begin
          mask_l_d  = mask;
          dwell_l_d = dwell;
          shadow_d  = 4'd0;
          cnt_d     = 4'd0;
          if (pick_first[2]) begin
            state_d = DONE;
            ch_d    = 2'd0;
          end else begin
            state_d = SCAN;
            ch_d    = pick_first[1:0];
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
          ch_d    = 2'd0;
        end
      end
      SCAN: begin
        if (cnt_q == dwell_l_q) begin
          shadow_d[ch_q] = mux_o;
          cnt_d          = 4'd0;
          if (pick_next[2]) begin
            state_d = DONE;
            ch_d    = 2'd0;
          end else begin
            ch_d = pick_next[1:0];
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        ch_d    = 2'd0;
      end
    endcase
  end

  // Frame captures the shadow (with the final sample) on entry to DONE.
  always_comb begin
    frame_d = frame_q;
    if (state_d == DONE) frame_d = shadow_d;
  end

  assign {s1, s2}    = ch_q;
  assign frame       = frame_q;
  assign frame_valid = (state_q == DONE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed bench for mux4_scan_ctrl with a behavioural 4:1 mux
// (a=1, b=0, c=1, d driven per test).
module tb_mux4_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cont;
  logic [3:0] mask;
  logic [3:0] dwell;
  logic       mux_o;
  logic       s1;
  logic       s2;
  logic [3:0] frame;
  logic       frame_valid;
  logic       busy;
  logic       d_in;
  logic [3:0] chv;

  int errs;
  int checks;

  mux4_scan_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cont        (cont),
    .mask        (mask),
    .dwell       (dwell),
    .mux_o       (mux_o),
    .s1          (s1),
    .s2          (s2),
    .frame       (frame),
    .frame_valid (frame_valid),
    .busy        (busy)
  );

  assign chv   = {d_in, 1'b1, 1'b0, 1'b1};
  assign mux_o = chv[{s1, s2}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [3:0] got,
    input logic [3:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".sel"},   {2'b00, s1, s2}, 4'd0);
    chk({tag, ".busy"},  {3'b0, busy}, 4'd0);
    chk({tag, ".fv"},    {3'b0, frame_valid}, 4'd0);
  endtask

  // Full mask, dwell 0: selects 0,1,2,3 then frame 1101 at cycle 5.
  task automatic run_full(input string tag);
    logic [1:0] sel_exp;
    mask  = 4'b1111;
    dwell = 4'd0;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0;
      sel_exp = (c <= 4) ? 2'(c - 1) : 2'd0;
      chk({tag, ".sel"},  {2'b00, s1, s2}, {2'b00, sel_exp});
      chk({tag, ".fv"},   {3'b0, frame_valid}, {3'b0, c == 5});
      chk({tag, ".busy"}, {3'b0, busy}, {3'b0, c <= 5});
      if (c >= 5) chk({tag, ".frame"}, frame, 4'b1101);
    end
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    cont   = 1'b0;
    mask   = 4'd0;
    dwell  = 4'd0;
    d_in   = 1'b1;

    step();
    step();
    chk_idle("rst");
    chk("rst.frame", frame, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_idle("post_rst");

    run_full("full");

    // Sparse mask, dwell 3.
    mask  = 4'b0101;
    dwell = 4'd3;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      start = 1'b0;
      chk("sp.sel", {2'b00, s1, s2},
          (c <= 4) ? 4'd0 : ((c <= 8) ? 4'd2 : 4'd0));
      chk("sp.fv",   {3'b0, frame_valid}, {3'b0, c == 9});
      chk("sp.busy", {3'b0, busy}, {3'b0, c <= 9});
    end
    chk("sp.frame", frame, 4'b0101);

    // Empty mask goes straight to DONE.
    mask  = 4'b0000;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("mz.fv",    {3'b0, frame_valid}, 4'd1);
    chk("mz.frame", frame, 4'b0000);
    chk("mz.sel",   {2'b00, s1, s2}, 4'd0);
    chk("mz.busy",  {3'b0, busy}, 4'd1);
    step();
    chk_idle("mz.after");

    // Continuous mode on channel 3, d toggled between frames.
    mask  = 4'b1000;
    dwell = 4'd1;
    cont  = 1'b1;
    d_in  = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      start = 1'b0;
      chk("ct.fv", {3'b0, frame_valid},
          {3'b0, (c % 3 == 0) && (c <= 9)});
      chk("ct.busy", {3'b0, busy}, {3'b0, c <= 9});
      if (c % 3 == 0 && c <= 9) begin
        chk("ct.frame", frame, {d_in, 3'b000});
        d_in = ~d_in;
        if (c == 9) cont = 1'b0;
      end else if (c <= 9) begin
        chk("ct.sel", {2'b00, s1, s2}, 4'd3);
      end
    end
    d_in = 1'b1;

    // Reset during channel 2 of a full scan.
    mask  = 4'b1111;
    dwell = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("ra.sel", {2'b00, s1, s2}, 4'd2);
    rst_n = 1'b0;
    #1;
    chk_idle("ra.now");
    chk("ra.frame", frame, 4'd0);
    step();
    chk_idle("ra.held");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk_idle("ra.quiet");
    end
    run_full("ra.full");

    // Start and config changes mid-scan are ignored.
    mask  = 4'b0101;
    dwell = 4'd1;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = (c == 1);
      if (c == 1) begin
        mask  = 4'b1111;
        dwell = 4'd3;
      end
      chk("ig.sel", {2'b00, s1, s2},
          (c <= 2) ? 4'd0 : ((c <= 4) ? 4'd2 : 4'd0));
      chk("ig.fv",   {3'b0, frame_valid}, {3'b0, c == 5});
      chk("ig.busy", {3'b0, busy}, {3'b0, c <= 5});
    end
    chk("ig.frame", frame, 4'b0101);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
